// File: rtl/board_scanout.sv
// board_scanout: turns VGA timing plus the packed board memory into a per-pixel
// cell_alive bit, owns the display half of the double buffer and swaps it at frame boundaries.
module board_scanout #(
    parameter int unsigned BOARD_SIZE  = 256,
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                                                clk_in,
    input  logic                                                rst_n_in,
    input  logic [10:0]                                         hcount_in,
    input  logic [9:0]                                          vcount_in,
    input  logic                                                hsync_in,
    input  logic                                                vsync_in,
    input  logic                                                blank_in,
    output logic                                                rd_en_out,
    output logic [2*$clog2(BOARD_SIZE)-$clog2(WORD_WIDTH):0]    rd_addr_out,
    input  logic [WORD_WIDTH-1:0]                               rd_data_in,
    input  logic                                                swap_req_in,
    output logic                                                swap_ack_out,
    output logic                                                disp_buf_out,
    output logic                                                frame_done_out,
    output logic                                                cell_alive_out,
    output logic [10:0]                                         hcount_out,
    output logic [9:0]                                          vcount_out,
    output logic                                                hsync_out,
    output logic                                                vsync_out,
    output logic                                                blank_out
);
    localparam int unsigned LB = $clog2(BOARD_SIZE);
    localparam int unsigned LW = $clog2(WORD_WIDTH);
    localparam int unsigned D  = MEM_LATENCY + 1;

    logic in_board, boundary, boundary_q, frame_edge, disp_buf, phase, inb_q;
    logic [WORD_WIDTH-1:0] shreg;
    logic [MEM_LATENCY-1:0] vld;
    logic [24:0] tl_d [D];

    assign in_board   = 32'(hcount_in) < BOARD_SIZE && 32'(vcount_in) < BOARD_SIZE;
    assign boundary   = hcount_in == '0 && 32'(vcount_in) == BOARD_SIZE;
    assign frame_edge = boundary && !boundary_q;
    assign rd_en_out  = in_board && hcount_in[LW-1:0] == '0;
    assign rd_addr_out = {disp_buf, vcount_in[LB-1:0], hcount_in[LB-1:LW]};
    assign {inb_q, hsync_out, vsync_out, blank_out, hcount_out, vcount_out} = tl_d[D-1];
    assign cell_alive_out = shreg[0] && inb_q;
    assign disp_buf_out   = disp_buf;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < D; i++) tl_d[i] <= '0;
            vld            <= '0;
            shreg          <= '0;
            phase          <= 1'b0;
            boundary_q     <= 1'b0;
            disp_buf       <= 1'b0;
            swap_ack_out   <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            tl_d[0] <= {in_board, hsync_in, vsync_in, blank_in, hcount_in, vcount_in};
            for (int i = 1; i < D; i++) tl_d[i] <= tl_d[i-1];
            vld[0] <= rd_en_out;
            for (int i = 1; i < MEM_LATENCY; i++) vld[i] <= vld[i-1];
            // each pixel spans two clocks; a load restarts the phase so the next clock shifts
            if (vld[MEM_LATENCY-1]) begin
                shreg <= rd_data_in;
                phase <= 1'b1;
            end else begin
                shreg <= phase ? shreg >> 1 : shreg;
                phase <= !phase;
            end
            boundary_q     <= boundary;
            frame_done_out <= frame_edge;
            swap_ack_out   <= frame_edge && swap_req_in;
            disp_buf       <= disp_buf ^ (frame_edge && swap_req_in);
        end
    end
endmodule

// File: tb/tb_board_scanout.sv
// tb_board_scanout: directed checks of board_scanout at MEM_LATENCY 2 (main), 1 and 4.
module tb_board_scanout;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, hsync, vsync, blank, swap_req;
    logic [10:0] hcount;
    logic [9:0] vcount;
    logic [31:0] mem [4096];

    logic rd_en0, rd_en1, rd_en2, ack0, ack1, ack2, disp0, disp1, disp2, fd0, fd1, fd2;
    logic cell0, cell1, cell2, hs0, hs1, hs2, vs0, vs1, vs2, bl0, bl1, bl2;
    logic [11:0] addr0, addr1, addr2;
    logic [31:0] rdat0, rdat1, rdat2;
    logic [10:0] hco0, hco1, hco2;
    logic [9:0] vco0, vco1, vco2;
    logic [31:0] p0 [2];
    logic [31:0] p1 [1];
    logic [31:0] p2 [4];

    int tests = 0, fails = 0, cyc = 0;
    int hh [16384];
    int vv [16384];
    logic hsh [16384];
    logic vsh [16384];
    logic blh [16384];

    board_scanout #(.MEM_LATENCY(2)) u0 (.clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank), .rd_en_out(rd_en0), .rd_addr_out(addr0),
        .rd_data_in(rdat0), .swap_req_in(swap_req), .swap_ack_out(ack0), .disp_buf_out(disp0),
        .frame_done_out(fd0), .cell_alive_out(cell0), .hcount_out(hco0), .vcount_out(vco0),
        .hsync_out(hs0), .vsync_out(vs0), .blank_out(bl0));
    board_scanout #(.MEM_LATENCY(1)) u1 (.clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank), .rd_en_out(rd_en1), .rd_addr_out(addr1),
        .rd_data_in(rdat1), .swap_req_in(swap_req), .swap_ack_out(ack1), .disp_buf_out(disp1),
        .frame_done_out(fd1), .cell_alive_out(cell1), .hcount_out(hco1), .vcount_out(vco1),
        .hsync_out(hs1), .vsync_out(vs1), .blank_out(bl1));
    board_scanout #(.MEM_LATENCY(4)) u2 (.clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank), .rd_en_out(rd_en2), .rd_addr_out(addr2),
        .rd_data_in(rdat2), .swap_req_in(swap_req), .swap_ack_out(ack2), .disp_buf_out(disp2),
        .frame_done_out(fd2), .cell_alive_out(cell2), .hcount_out(hco2), .vcount_out(vco2),
        .hsync_out(hs2), .vsync_out(vs2), .blank_out(bl2));

    // memory models; data on non-read cycles is all-ones so stray loads show up
    always @(posedge clk) begin
        p0[0] <= rd_en0 ? mem[addr0] : '1;
        p0[1] <= p0[0];
        p1[0] <= rd_en1 ? mem[addr1] : '1;
        p2[0] <= rd_en2 ? mem[addr2] : '1;
        for (int i = 1; i < 4; i++) p2[i] <= p2[i-1];
    end
    assign rdat0 = p0[1];
    assign rdat1 = p1[0];
    assign rdat2 = p2[3];

    function automatic logic cexp(input int h, input int v, input logic b);
        logic [31:0] w;
        if (h >= 256 || v >= 256) return 1'b0;
        w = mem[{b, v[7:0], h[7:5]}];
        return w[h[4:0]];
    endfunction

    task automatic drive(input int h, input int v);
        @(posedge clk);
        #1;
        hcount = h[10:0];
        vcount = v[9:0];
        hsync  = h[2];
        vsync  = v[0] ^ h[5];
        blank  = h >= 256 || v >= 256;
        hh[cyc] = h; vv[cyc] = v; hsh[cyc] = hsync; vsh[cyc] = vsync; blh[cyc] = blank;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; swap_req = 1'b0;
        hcount = 11'd5; vcount = 10'd5; hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        tests++; if (cell0 !== 1'b0) begin fails++; $display("FAIL reset_cell got=%b exp=0", cell0); end
        tests++; if (hco0 !== 11'd0) begin fails++; $display("FAIL reset_hcount got=%0d exp=0", hco0); end
        tests++; if (vco0 !== 10'd0) begin fails++; $display("FAIL reset_vcount got=%0d exp=0", vco0); end
        tests++; if ({hs0, vs0, bl0} !== 3'b000) begin fails++; $display("FAIL reset_sync got=%b exp=000", {hs0, vs0, bl0}); end
        tests++; if ({ack0, fd0, disp0} !== 3'b000) begin fails++; $display("FAIL reset_ctrl got=%b exp=000", {ack0, fd0, disp0}); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_single_cell();
        int n, ones, t0;
        logic [11:0] ea;
        logic ee;
        t0 = cyc; ones = 0;
        mem[12'h028] = 32'h0000_0001;
        for (int v = 4; v <= 6; v++)
            for (int h = 0; h <= 300; h++)
                repeat (2) begin
                    drive(h, v);
                    n = cyc - 1;
                    ee = h < 256 && h % 32 == 0;
                    ea = {1'b0, v[7:0], h[7:5]};
                    tests++; if (rd_en0 !== ee) begin fails++; $display("FAIL rd_en h=%0d v=%0d got=%b exp=%b", h, v, rd_en0, ee); end
                    if (ee) begin
                        tests++; if (addr0 !== ea) begin fails++; $display("FAIL rd_addr h=%0d v=%0d got=%h exp=%h", h, v, addr0, ea); end
                    end
                    if (n - t0 >= 5) begin
                        ones += int'(cell0);
                        tests++;
                        if (cell0 !== cexp(hh[n-3], vv[n-3], 1'b0) || hco0 !== 11'(hh[n-3]) || vco0 !== 10'(vv[n-3]) ||
                            {hs0, vs0, bl0} !== {hsh[n-3], vsh[n-3], blh[n-3]}) begin
                            fails++;
                            $display("FAIL align_l2 cyc=%0d got=%b/%0d/%0d/%b%b%b exp=%b/%0d/%0d/%b%b%b", n, cell0, hco0, vco0, hs0, vs0, bl0,
                                     cexp(hh[n-3], vv[n-3], 1'b0), hh[n-3], vv[n-3], hsh[n-3], vsh[n-3], blh[n-3]);
                        end
                        tests++;
                        if (cell1 !== cexp(hh[n-2], vv[n-2], 1'b0) || hco1 !== 11'(hh[n-2]) || vco1 !== 10'(vv[n-2])) begin
                            fails++; $display("FAIL align_l1 cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", n, cell1, hco1, vco1, cexp(hh[n-2], vv[n-2], 1'b0), hh[n-2], vv[n-2]);
                        end
                        tests++;
                        if (cell2 !== cexp(hh[n-5], vv[n-5], 1'b0) || hco2 !== 11'(hh[n-5]) || vco2 !== 10'(vv[n-5])) begin
                            fails++; $display("FAIL align_l4 cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", n, cell2, hco2, vco2, cexp(hh[n-5], vv[n-5], 1'b0), hh[n-5], vv[n-5]);
                        end
                    end
                end
        tests++; if (ones != 2) begin fails++; $display("FAIL single_cell_count got=%0d exp=2", ones); end
        mem[12'h028] = 32'h0;
    endtask

    task automatic test_row_words();
        int n, ones, t0;
        t0 = cyc; ones = 0;
        for (int w = 0; w < 8; w++) mem[w] = 32'h8000_0000;
        for (int h = 0; h < 1024; h++)
            repeat (2) begin
                drive(h, 0);
                n = cyc - 1;
                if (n - t0 >= 5) begin
                    ones += int'(cell0);
                    tests++;
                    if (cell0 !== cexp(hh[n-3], 0, 1'b0) || hco0 !== 11'(hh[n-3])) begin
                        fails++; $display("FAIL row_l2 hco=%0d got=%b exp=%b", hco0, cell0, cexp(hh[n-3], 0, 1'b0));
                    end
                    tests++;
                    if (cell1 !== cexp(hh[n-2], 0, 1'b0) || cell2 !== cexp(hh[n-5], 0, 1'b0)) begin
                        fails++; $display("FAIL row_l1l4 cyc=%0d got=%b%b exp=%b%b", n, cell1, cell2, cexp(hh[n-2], 0, 1'b0), cexp(hh[n-5], 0, 1'b0));
                    end
                end
            end
        tests++; if (ones != 16) begin fails++; $display("FAIL row_count got=%0d exp=16", ones); end
    endtask

    task automatic test_swap();
        swap_req = 1'b1;
        for (int h = 0; h < 4; h++)
            repeat (2) begin
                drive(h, 100);
                tests++; if ({disp0, ack0} !== 2'b00) begin fails++; $display("FAIL swap_midframe got=%b exp=00", {disp0, ack0}); end
            end
        drive(0, 100);
        tests++; if (addr0[11] !== 1'b0) begin fails++; $display("FAIL swap_midframe_addr got=%h exp=msb0", addr0); end
        repeat (2) drive(700, 255);
        tests++; if (disp0 !== 1'b0) begin fails++; $display("FAIL swap_pre got=%b exp=0", disp0); end
        drive(0, 256);
        tests++; if ({fd0, ack0, disp0} !== 3'b000) begin fails++; $display("FAIL swap_bnd0 got=%b exp=000", {fd0, ack0, disp0}); end
        drive(0, 256);
        tests++; if ({fd0, ack0, disp0} !== 3'b111) begin fails++; $display("FAIL swap_bnd1 got=%b exp=111", {fd0, ack0, disp0}); end
        tests++; if ({disp1, disp2, ack1, ack2} !== 4'b1111) begin fails++; $display("FAIL swap_l1l4 got=%b exp=1111", {disp1, disp2, ack1, ack2}); end
        drive(1, 256);
        swap_req = 1'b0;
        tests++; if ({fd0, ack0, disp0} !== 3'b001) begin fails++; $display("FAIL swap_after got=%b exp=001", {fd0, ack0, disp0}); end
        drive(0, 0);
        tests++; if ({rd_en0, addr0} !== {1'b1, 12'h800}) begin fails++; $display("FAIL swap_addr got=%b/%h exp=1/800", rd_en0, addr0); end
        repeat (2) drive(5, 0);
        repeat (2) drive(0, 256);
        tests++; if ({fd0, ack0, disp0} !== 3'b101) begin fails++; $display("FAIL frame_noreq got=%b exp=101", {fd0, ack0, disp0}); end
        drive(1, 256);
        tests++; if (fd0 !== 1'b0) begin fails++; $display("FAIL frame_pulse got=%b exp=0", fd0); end
    endtask

    task automatic test_swap_held();
        logic eb;
        int acks;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        eb = 1'b0; acks = 0;
        tests++; if (disp0 !== 1'b0) begin fails++; $display("FAIL held_reset got=%b exp=0", disp0); end
        swap_req = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int h = 0; h < 3; h++)
                repeat (2) begin
                    drive(h, 50);
                    acks += int'(ack0);
                    tests++; if ({ack0, disp0} !== {1'b0, eb}) begin fails++; $display("FAIL held_mid f=%0d got=%b exp=%b", f, {ack0, disp0}, {1'b0, eb}); end
                end
            drive(0, 256);
            acks += int'(ack0);
            drive(0, 256);
            acks += int'(ack0);
            eb = ~eb;
            tests++; if ({fd0, ack0, disp0} !== {2'b11, eb}) begin fails++; $display("FAIL held_bnd f=%0d got=%b exp=%b", f, {fd0, ack0, disp0}, {2'b11, eb}); end
            drive(1, 256);
            acks += int'(ack0);
            tests++; if ({fd0, ack0, disp0} !== {2'b00, eb}) begin fails++; $display("FAIL held_after f=%0d got=%b exp=%b", f, {fd0, ack0, disp0}, {2'b00, eb}); end
        end
        tests++; if (acks != 3) begin fails++; $display("FAIL held_acks got=%0d exp=3", acks); end
        swap_req = 1'b0;
    endtask

    task automatic test_reset_midline();
        int n, rel;
        logic e;
        for (int w = 0; w < 8; w++) begin
            mem[{1'b0, 8'd10, 3'(w)}] = '1;
            mem[{1'b1, 8'd10, 3'(w)}] = '1;
        end
        for (int h = 0; h <= 40; h++) repeat (2) drive(h, 10);
        tests++; if (cell0 !== 1'b1) begin fails++; $display("FAIL midline_pre got=%b exp=1", cell0); end
        #1 rst_n = 1'b0;
        #1;
        tests++; if ({cell0, hco0, vco0, disp0} !== 23'd0) begin fails++; $display("FAIL midline_async got=%b/%0d/%0d/%b exp=0", cell0, hco0, vco0, disp0); end
        repeat (2) begin
            drive(41, 10);
            tests++; if ({cell0, hco0} !== 12'd0) begin fails++; $display("FAIL midline_held got=%b/%0d exp=0", cell0, hco0); end
        end
        @(negedge clk) rst_n = 1'b1;
        rel = cyc;
        for (int h = 42; h <= 100; h++)
            repeat (2) begin
                drive(h, 10);
                n = cyc - 1;
                e = hh[n-3] >= 64 ? cexp(hh[n-3], 10, 1'b0) : 1'b0;
                tests++; if (cell0 !== e) begin fails++; $display("FAIL midline_cell hin=%0d got=%b exp=%b", hh[n-3], cell0, e); end
                if (n >= rel + 3) begin
                    tests++; if (hco0 !== 11'(hh[n-3])) begin fails++; $display("FAIL midline_hcount got=%0d exp=%0d", hco0, hh[n-3]); end
                end
            end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        test_reset();
        test_single_cell();
        test_row_words();
        test_swap();
        test_swap_held();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule
